mem_arbiter: RTL and testbench

Sequences and shares the single instruction/data memory port. After reset it routes BIOS boot-load writes into memory starting at address 0, then arbitrates each cycle between the instruction-fetch stage and the data-memory stage. It drives the memory CS/WE/OE/address/data lines and issues a stall that holds the PC and IF/ID register whenever fetch is not served.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: BIOS boot loader plus fetch/data arbiter for a single shared memory port.
// Optional MEM_ARB_FAIR_EN gives a starved fetch priority on the next contested cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BOOT_WORDS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  boot_start,
    input  logic                  boot_valid,
    input  logic [DATA_WIDTH-1:0] boot_data,
    output logic                  boot_ready,
    output logic                  boot_done,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_grant,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_grant,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BOOT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    boot_done_q, boot_done_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, dm_rdata_q;
    logic                    if_valid_q, dm_valid_q;
    logic                    starved;
    logic                    last_word;

    assign last_word = (cnt_q == ADDR_WIDTH'(BOOT_WORDS - 1));

`ifdef MEM_ARB_FAIR_EN
    logic if_starved_q, if_starved_d;
    assign starved      = if_starved_q;
    assign if_starved_d = (dm_grant && if_req) ? 1'b1 : (if_grant ? 1'b0 : if_starved_q);
    always_ff @(posedge clock or posedge reset)
        if (reset) if_starved_q <= 1'b0;
        else       if_starved_q <= if_starved_d;
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_done_d = boot_done_q;
        boot_ready  = 1'b0;
        if_grant    = 1'b0;
        dm_grant    = 1'b0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_oe      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: if (boot_start) state_d = BOOT;
            BOOT: begin
                boot_ready = 1'b1;
                if (boot_valid) begin
                    mem_cs    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q;
                    mem_wdata = boot_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d     = RUN;
                        boot_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if_grant = if_req && (!dm_req || starved);
                dm_grant = dm_req && !if_grant;
                mem_cs   = if_grant || dm_grant;
                mem_we   = dm_grant && dm_we;
                mem_oe   = if_grant || (dm_grant && !dm_we);
                mem_addr = if_grant ? if_addr : (dm_grant ? dm_addr : '0);
                mem_wdata = (dm_grant && dm_we) ? dm_wdata : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall = (state_q != RUN) || (if_req && !if_grant);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            boot_done_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_done_q <= boot_done_d;
            if_valid_q  <= if_grant;
            dm_valid_q  <= dm_grant && !dm_we;
            if (if_grant)           if_rdata_q <= mem_rdata;
            if (dm_grant && !dm_we) dm_rdata_q <= mem_rdata;
        end
    end

    assign boot_done = boot_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus a reset-mid-boot sequence for mem_arbiter (BOOT_WORDS=4).
module tb_mem_arbiter;
    logic        clock = 1'b0, reset = 1'b1;
    logic        boot_start = 0, boot_valid = 0, boot_ready, boot_done;
    logic [31:0] boot_data = 0;
    logic        if_req = 0, if_grant, if_valid;
    logic [31:0] if_addr = 0, if_rdata;
    logic        dm_req = 0, dm_we = 0, dm_grant, dm_valid;
    logic [31:0] dm_addr = 0, dm_wdata = 0, dm_rdata;
    logic        stall, mem_cs, mem_we, mem_oe;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:15];
    int          errors = 0, checks = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_WORDS(4)) dut (
        .clock(clock), .reset(reset), .boot_start(boot_start), .boot_valid(boot_valid),
        .boot_data(boot_data), .boot_ready(boot_ready), .boot_done(boot_done),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_rdata(if_rdata),
        .if_valid(if_valid), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_grant(dm_grant), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_oe ? mem[mem_addr[3:0]] : 32'h0;
    always @(posedge clock) if (mem_cs && mem_we) mem[mem_addr[3:0]] <= mem_wdata;

    typedef struct {
        logic bs, bv; logic [31:0] bdata;
        logic ir; logic [31:0] ia;
        logic dr, dwe; logic [31:0] da, dwd;
        logic [7:0] fl; logic [31:0] ma, mwd;
        logic iv; logic [31:0] ird;
        logic dv; logic [31:0] drd;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic bs, bv, input logic [31:0] bdata, input logic ir,
                       input logic [31:0] ia, input logic dr, dwe, input logic [31:0] da, dwd,
                       input logic [7:0] fl, input logic [31:0] ma, mwd, input logic iv,
                       input logic [31:0] ird, input logic dv, input logic [31:0] drd);
        vec_t v;
        v = '{bs, bv, bdata, ir, ia, dr, dwe, da, dwd, fl, ma, mwd, iv, ird, dv, drd};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flags();
        return {boot_ready, boot_done, if_grant, dm_grant, stall, mem_cs, mem_we, mem_oe};
    endfunction

`ifdef MEM_ARB_FAIR_EN
    localparam logic [31:0] IRD_HELD = 32'hA3;
`else
    localparam logic [31:0] IRD_HELD = 32'hA2;
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        // flags = {boot_ready, boot_done, if_grant, dm_grant, stall, mem_cs, mem_we, mem_oe}
        add(0,0,0,     1,2, 0,0,0,0,      8'b00001000, 0, 0,     0,0,      0,0);
        add(1,0,0,     0,0, 0,0,0,0,      8'b00001000, 0, 0,     0,0,      0,0);
        add(0,1,'hA0,  0,0, 1,0,7,0,      8'b10001110, 0, 'hA0,  0,0,      0,0);
        add(0,1,'hA1,  0,0, 0,0,0,0,      8'b10001110, 1, 'hA1,  0,0,      0,0);
        add(0,0,'hEE,  0,0, 0,0,0,0,      8'b10001000, 0, 0,     0,0,      0,0);
        add(0,1,'hA2,  0,0, 0,0,0,0,      8'b10001110, 2, 'hA2,  0,0,      0,0);
        add(0,1,'hA3,  0,0, 0,0,0,0,      8'b10001110, 3, 'hA3,  0,0,      0,0);
        add(1,1,'hBB,  0,0, 0,0,0,0,      8'b01000000, 0, 0,     0,0,      0,0);
        add(0,0,0,     1,2, 0,0,0,0,      8'b01100101, 2, 0,     0,0,      0,0);
        add(0,0,0,     0,0, 0,0,0,0,      8'b01000000, 0, 0,     1,'hA2,   0,0);
        add(0,0,0,     1,3, 1,0,1,0,      8'b01011101, 1, 0,     0,'hA2,   0,0);
`ifdef MEM_ARB_FAIR_EN
        add(0,0,0,     1,3, 1,0,1,0,      8'b01100101, 3, 0,     0,'hA2,   1,'hA1);
        add(0,0,0,     1,3, 1,0,1,0,      8'b01011101, 1, 0,     1,'hA3,   0,'hA1);
`else
        add(0,0,0,     1,3, 1,0,1,0,      8'b01011101, 1, 0,     0,'hA2,   1,'hA1);
        add(0,0,0,     1,3, 1,0,1,0,      8'b01011101, 1, 0,     0,'hA2,   1,'hA1);
`endif
        add(0,0,0,     0,0, 0,0,0,0,      8'b01000000, 0, 0,     0,IRD_HELD, 1,'hA1);
        add(0,0,0,     0,0, 1,1,5,'h55,   8'b01010110, 5, 'h55,  0,IRD_HELD, 0,'hA1);
        add(0,0,0,     1,5, 0,0,0,0,      8'b01100101, 5, 0,     0,IRD_HELD, 0,'hA1);
        add(0,0,0,     0,0, 0,0,0,0,      8'b01000000, 0, 0,     1,'h55,   0,'hA1);

        #12;
        check("rst_flags", {24'h0, flags()}, 32'h08);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_valids", {30'h0, if_valid, dm_valid}, 0);
        @(negedge clock) reset = 1'b0;
        foreach (vq[i]) begin
            @(negedge clock);
            {boot_start, boot_valid, boot_data} = {vq[i].bs, vq[i].bv, vq[i].bdata};
            {if_req, if_addr} = {vq[i].ir, vq[i].ia};
            {dm_req, dm_we, dm_addr, dm_wdata} = {vq[i].dr, vq[i].dwe, vq[i].da, vq[i].dwd};
            #1;
            check($sformatf("v%0d_flags", i), {24'h0, flags()}, {24'h0, vq[i].fl});
            check($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].ma);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vq[i].mwd);
            check($sformatf("v%0d_if", i), {31'h0, if_valid} ^ (if_rdata << 1), {31'h0, vq[i].iv} ^ (vq[i].ird << 1));
            check($sformatf("v%0d_dm", i), {31'h0, dm_valid} ^ (dm_rdata << 1), {31'h0, vq[i].dv} ^ (vq[i].drd << 1));
        end
        check("mem3_boot", mem[3], 32'hA3);

        @(negedge clock);
        {boot_start, boot_valid, if_req, dm_req, dm_we} = '0;
        reset = 1'b1;
        #1;
        check("rst2_if_rdata", if_rdata, 0);
        check("rst2_boot_done", {31'h0, boot_done}, 0);
        @(negedge clock) reset = 1'b0;
        boot_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            boot_start = 1'b0; boot_valid = 1'b1; boot_data = 32'hB0 + i;
            #1 check($sformatf("b%0d_addr", i), mem_addr, i);
        end
        @(negedge clock);
        boot_valid = 1'b0;
        reset = 1'b1;
        #1 check("midrst_flags", {24'h0, flags()}, 32'h08);
        @(negedge clock) reset = 1'b0;
        boot_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            boot_start = 1'b0; boot_valid = 1'b1; boot_data = 32'hC0 + i;
            #1;
            check($sformatf("c%0d_addr", i), mem_addr, i);
            check($sformatf("c%0d_done", i), {30'h0, boot_done, stall}, 32'h1);
        end
        @(negedge clock);
        boot_valid = 1'b0;
        #1;
        check("c_done_after", {31'h0, boot_done}, 1);
        check("c_mem0", mem[0], 32'hC0);
        check("c_mem3", mem[3], 32'hC3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
